// File: rtl/uart_rx_core.sv
// uart_rx_core: 16x-oversampled UART receiver with majority-vote sampling,
// optional parity, stop-bit checking and a single-byte holding register.
module uart_rx_core #(
  parameter int FRAMING_CHECK = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       baud_clock,
  input  logic       rx,
  input  logic       bit8,
  input  logic       parity_en,
  input  logic       odd_n_even,
  input  logic       read_rx_byte,
  output logic [7:0] rx_byte,
  output logic       rx_ready,
  output logic       parity_err,
  output logic       framing_err,
  output logic       overflow,
  output logic       rx_idle
);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t     r_state;
  logic       r_sync1, r_sync2, r_bit8, r_par_en, r_odd, r_par_bad, r_idle;
  logic [2:0] r_win, r_bit;
  logic [3:0] r_samp;
  logic [7:0] r_shift, r_byte;
  logic       r_ready, r_perr, r_ferr, r_ovf;
  logic       w_maj, w_last, w_par, w_load;
  assign w_maj  = (r_win[0] & r_win[1]) | (r_win[0] & r_win[2]) | (r_win[1] & r_win[2]);
  assign w_last = r_bit == (r_bit8 ? 3'd7 : 3'd6);
  assign w_par  = ^(r_bit8 ? r_shift : {1'b0, r_shift[7:1]});
  assign w_load = baud_clock && r_state == STOP && r_samp == 4'd9;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_win     <= 3'b111;
      r_state   <= IDLE;
      r_idle    <= 1'b1;
      r_samp    <= '0;
      r_bit     <= '0;
      r_shift   <= '0;
      r_bit8    <= 1'b0;
      r_par_en  <= 1'b0;
      r_odd     <= 1'b0;
      r_par_bad <= 1'b0;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
      if (baud_clock) begin
        r_win <= {r_win[1:0], r_sync2};
        if (r_state != IDLE) r_samp <= r_samp + 4'd1;
        case (r_state)
          IDLE: if (!r_sync2) begin
            r_state   <= START;
            r_idle    <= 1'b0;
            r_samp    <= '0;
            r_bit8    <= bit8;
            r_par_en  <= parity_en;
            r_odd     <= odd_n_even;
            r_par_bad <= 1'b0;
          end
          START: if (r_samp == 4'd9 && w_maj) begin
            r_state <= IDLE;
            r_idle  <= 1'b1;
          end else if (r_samp == 4'd15) begin
            r_state <= DATA;
            r_bit   <= '0;
          end
          DATA: begin
            if (r_samp == 4'd9) r_shift <= {w_maj, r_shift[7:1]};
            if (r_samp == 4'd15) begin
              if (w_last) r_state <= r_par_en ? PARITY : STOP;
              else r_bit <= r_bit + 3'd1;
            end
          end
          PARITY: begin
            if (r_samp == 4'd9) r_par_bad <= (w_par ^ w_maj) != r_odd;
            if (r_samp == 4'd15) r_state <= STOP;
          end
          STOP: if (r_samp == 4'd9) begin
            r_state <= IDLE;
            r_idle  <= 1'b1;
          end
          default: begin
            r_state <= IDLE;
            r_idle  <= 1'b1;
          end
        endcase
      end
    end
  end
  // a load coinciding with a read keeps the byte and never flags overflow
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_byte  <= '0;
      r_ready <= 1'b0;
      r_perr  <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_load) begin
      r_byte  <= r_bit8 ? r_shift : {1'b0, r_shift[7:1]};
      r_ready <= 1'b1;
      r_perr  <= r_par_en & r_par_bad;
      r_ferr  <= (FRAMING_CHECK != 0) && !w_maj;
      r_ovf   <= r_ready & ~read_rx_byte;
    end else if (read_rx_byte && r_ready) begin
      r_ready <= 1'b0;
      r_perr  <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovf   <= 1'b0;
    end
  end
  assign rx_byte     = r_byte;
  assign rx_ready    = r_ready;
  assign parity_err  = r_perr;
  assign framing_err = r_ferr;
  assign overflow    = r_ovf;
  assign rx_idle     = r_idle;
endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: directed frame vectors against uart_rx_core, with a
// second instance built without stop-bit checking.
module tb_uart_rx_core;
  logic clk = 0, reset_n = 0, baud_clock = 0, rx = 1;
  logic bit8 = 1, parity_en = 0, odd_n_even = 0, read_rx_byte = 0;
  logic [7:0] rx_byte, n_byte;
  logic rx_ready, parity_err, framing_err, overflow, rx_idle;
  logic n_ready, n_perr, n_ferr, n_ovf, n_idle;
  int total = 0, bad = 0;

  uart_rx_core #(.FRAMING_CHECK(1)) dut (
    .clk(clk), .reset_n(reset_n), .baud_clock(baud_clock), .rx(rx),
    .bit8(bit8), .parity_en(parity_en), .odd_n_even(odd_n_even),
    .read_rx_byte(read_rx_byte), .rx_byte(rx_byte), .rx_ready(rx_ready),
    .parity_err(parity_err), .framing_err(framing_err), .overflow(overflow),
    .rx_idle(rx_idle));

  uart_rx_core #(.FRAMING_CHECK(0)) dut_nf (
    .clk(clk), .reset_n(reset_n), .baud_clock(baud_clock), .rx(rx),
    .bit8(bit8), .parity_en(parity_en), .odd_n_even(odd_n_even),
    .read_rx_byte(read_rx_byte), .rx_byte(n_byte), .rx_ready(n_ready),
    .parity_err(n_perr), .framing_err(n_ferr), .overflow(n_ovf),
    .rx_idle(n_idle));

  always #5 clk = ~clk;

  initial begin
    int c = 0;
    forever begin
      @(negedge clk);
      c++;
      baud_clock = (c % 4 == 0);
    end
  end

  typedef struct {
    logic [7:0] d;
    logic b8, pe, od, pb, sb;
    logic [7:0] eb;
    logic e_perr, e_ferr;
  } vec_t;
  vec_t v[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic bit_wait();
    repeat (64) @(negedge clk);
  endtask

  // config inputs are inverted during the frame; the receiver must use the latched values
  task automatic send(input logic [7:0] d, input logic b8, pe, od, pb, sb);
    bit8 = b8; parity_en = pe; odd_n_even = od;
    rx = 0;
    bit_wait();
    bit8 = ~b8; parity_en = ~pe; odd_n_even = ~od;
    for (int i = 0; i < (b8 ? 8 : 7); i++) begin
      rx = d[i];
      bit_wait();
    end
    if (pe) begin
      rx = pb;
      bit_wait();
    end
    rx = sb;
    bit_wait();
    rx = 1;
    bit8 = b8; parity_en = pe; odd_n_even = od;
    repeat (100) @(negedge clk);
  endtask

  task automatic do_read();
    @(negedge clk) read_rx_byte = 1;
    @(negedge clk) read_rx_byte = 0;
    @(negedge clk);
  endtask

  initial begin
    v[0] = '{8'hA5, 1, 0, 0, 0, 1, 8'hA5, 0, 0};
    v[1] = '{8'h37, 1, 1, 0, 0, 1, 8'h37, 1, 0};
    v[2] = '{8'h37, 1, 1, 0, 1, 1, 8'h37, 0, 0};
    v[3] = '{8'h3C, 1, 0, 0, 0, 0, 8'h3C, 0, 1};
    v[4] = '{8'h55, 0, 0, 0, 0, 1, 8'h55, 0, 0};
    v[5] = '{8'h96, 1, 1, 1, 1, 1, 8'h96, 0, 0};
    v[6] = '{8'h2B, 0, 1, 0, 1, 1, 8'h2B, 1, 0};
    v[7] = '{8'h01, 1, 1, 1, 0, 0, 8'h01, 0, 1};
    v[8] = '{8'hD5, 0, 0, 0, 0, 1, 8'h55, 0, 0};

    repeat (3) @(negedge clk);
    chk("rst_ready", rx_ready, 0);
    chk("rst_byte", rx_byte, 0);
    chk("rst_idle", rx_idle, 1);
    chk("rst_flags", {parity_err, framing_err, overflow}, 0);
    reset_n = 1;
    repeat (20) @(negedge clk);

    rx = 0;
    repeat (12) @(negedge clk);
    rx = 1;
    repeat (120) @(negedge clk);
    chk("false_start_ready", rx_ready, 0);
    chk("false_start_idle", rx_idle, 1);

    for (int k = 0; k < 9; k++) begin
      send(v[k].d, v[k].b8, v[k].pe, v[k].od, v[k].pb, v[k].sb);
      chk($sformatf("v%0d_ready", k), rx_ready, 1);
      chk($sformatf("v%0d_byte", k), rx_byte, v[k].eb);
      chk($sformatf("v%0d_perr", k), parity_err, v[k].e_perr);
      chk($sformatf("v%0d_ferr", k), framing_err, v[k].e_ferr);
      chk($sformatf("v%0d_ovf", k), overflow, 0);
      chk($sformatf("v%0d_idle", k), rx_idle, 1);
      chk($sformatf("v%0d_nf_byte", k), n_byte, v[k].eb);
      chk($sformatf("v%0d_nf_ferr", k), n_ferr, 0);
      do_read();
      chk($sformatf("v%0d_rd_ready", k), rx_ready, 0);
      chk($sformatf("v%0d_rd_flags", k), {parity_err, framing_err, overflow}, 0);
    end

    send(8'h11, 1, 0, 0, 0, 1);
    send(8'h22, 1, 0, 0, 0, 1);
    chk("ovf_byte", rx_byte, 8'h22);
    chk("ovf_ready", rx_ready, 1);
    chk("ovf_flag", overflow, 1);
    do_read();
    chk("ovf_rd_flag", overflow, 0);
    chk("ovf_rd_ready", rx_ready, 0);
    do_read();
    chk("idle_read_ready", rx_ready, 0);

    send(8'h11, 1, 0, 0, 0, 1);
    chk("pre_rst_ready", rx_ready, 1);
    bit8 = 1; parity_en = 0;
    rx = 0;
    bit_wait();
    for (int i = 0; i < 4; i++) begin
      rx = 0;
      bit_wait();
    end
    rx = 1;
    repeat (32) @(negedge clk);
    reset_n = 0;
    repeat (3) @(negedge clk);
    chk("mid_rst_ready", rx_ready, 0);
    chk("mid_rst_byte", rx_byte, 0);
    chk("mid_rst_idle", rx_idle, 1);
    chk("mid_rst_flags", {parity_err, framing_err, overflow}, 0);
    reset_n = 1;
    repeat (32 + 64 * 4 + 100) @(negedge clk);
    chk("post_rst_ready", rx_ready, 0);
    chk("post_rst_idle", rx_idle, 1);
    send(8'h5A, 1, 0, 0, 0, 1);
    chk("post_rst_byte", rx_byte, 8'h5A);
    chk("post_rst_frame_ready", rx_ready, 1);
    chk("post_rst_frame_flags", {parity_err, framing_err, overflow}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
